// File: rtl/qft_phase_sequencer_pkg.sv
// qft_phase_sequencer_pkg: fixed-point widths and angle constants shared by the phase sequencer
`ifndef FIXED_POINT_PARAMS_VH
`define FIXED_POINT_PARAMS_VH
`define TOTAL_WIDTH 8
`define FRAC_WIDTH 4
`endif

package qft_phase_sequencer_pkg;
    localparam int TW = `TOTAL_WIDTH;
    localparam int FW = `FRAC_WIDTH;
    // 2*pi, pi and pi/2 in Q15, rounded to FW fractional bits
    localparam int TWO_PI_I = ((205887 << FW) + 16384) >>> 15;
    localparam int PI_I = ((102944 << FW) + 16384) >>> 15;
    localparam int HALF_PI_I = ((51472 << FW) + 16384) >>> 15;
    localparam logic signed [TW:0] TWO_PI = (TW+1)'(TWO_PI_I);
    localparam logic signed [TW:0] PI = (TW+1)'(PI_I);
    localparam logic signed [TW:0] HALF_PI = (TW+1)'(HALF_PI_I);
endpackage

// File: rtl/qft_phase_sequencer_wrap.sv
// phase_wrap: single-step fold of a widened angle back into [-2pi, 2pi)
module phase_wrap
    import qft_phase_sequencer_pkg::*;
(
    input  logic signed [TW:0]   v,
    output logic signed [TW-1:0] y
);
    logic signed [TW:0] f;
    always_comb f = (v >= TWO_PI) ? v - TWO_PI : (v < -TWO_PI) ? v + TWO_PI : v;
    assign y = f[TW-1:0];
endmodule

// File: rtl/qft_phase_sequencer.sv
// qft_phase_sequencer: emits N wrapped phase samples with sine/cosine operands over a valid/ready handshake
module qft_phase_sequencer
    import qft_phase_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic signed [TW-1:0] phase_init,
    input  logic signed [TW-1:0] phase_step,
    input  logic [CNT_WIDTH-1:0] num_samples,
    output logic signed [TW-1:0] x_sin,
    output logic signed [TW-1:0] x_cos,
    output logic [CNT_WIDTH-1:0] idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, nxt;
    logic signed [TW-1:0] acc, step, acc_nx, cos_v;
    logic signed [TW:0] acc_in, cos_in;
    logic [CNT_WIDTH-1:0] n, cnt;
    logic hs, last, take;

    assign out_valid = state == RUN;
    assign busy = state == RUN;
    assign done = state == DONE;
    assign hs = out_valid & out_ready;
    assign last = cnt == n - CNT_WIDTH'(1);
    assign take = (state == IDLE) & start & ~abort;
    assign idx = cnt;

    // one fold serves both the initial load and each step, since they never coincide
    assign acc_in = (state == IDLE) ? {phase_init[TW-1], phase_init} : {acc[TW-1], acc} + {step[TW-1], step};
    assign cos_in = {acc[TW-1], acc} + HALF_PI;

    phase_wrap u_acc_wrap (.v(acc_in), .y(acc_nx));
    phase_wrap u_cos_wrap (.v(cos_in), .y(cos_v));

    // operands read as zero whenever no sample is being presented
    assign x_sin = out_valid ? acc : '0;
    assign x_cos = out_valid ? cos_v : '0;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = take ? ((num_samples == '0) ? DONE : RUN) : IDLE;
            RUN: nxt = abort ? IDLE : (hs && last) ? DONE : RUN;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc <= '0;
            step <= '0;
            n <= '0;
            cnt <= '0;
        end else begin
            state <= nxt;
            if (take) begin
                acc <= acc_nx;
                step <= phase_step;
                n <= num_samples;
                cnt <= '0;
            end else if (state == RUN && !abort && hs && !last) begin
                acc <= acc_nx;
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_qft_phase_sequencer.sv
// tb_qft_phase_sequencer: table-driven runs checked against a queued reference model, plus abort/reset sequences
module tb_qft_phase_sequencer;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
    logic signed [7:0] phase_init = 0, phase_step = 0, x_sin, x_cos;
    logic [7:0] num_samples = 0, idx;
    logic out_valid, busy, done;

    qft_phase_sequencer #(.CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .phase_init(phase_init), .phase_step(phase_step), .num_samples(num_samples),
        .x_sin(x_sin), .x_cos(x_cos), .idx(idx), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int s; int c; int k;} exp_t;
    typedef struct {int init; int step; int n; int bp;} run_t;
    typedef struct {int r; int k; int s; int c;} spot_t;

    exp_t q[$];
    int errors = 0, checks = 0;
    int obs_s[256], obs_c[256];
    run_t runs[7];
    spot_t spots[9];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int wrapm(input int v);
        return (v >= 101) ? v - 101 : (v < -101) ? v + 101 : v;
    endfunction

    task automatic run(input run_t r);
        int acc, hsn, edges, prev_s, prev_i;
        bit held, got_done;
        exp_t e;
        q.delete();
        acc = wrapm(r.init);
        for (int k = 0; k < r.n; k++) begin
            q.push_back('{acc, wrapm(acc + 25), k});
            acc = wrapm(acc + r.step);
        end
        @(negedge clk);
        phase_init = 8'(r.init);
        phase_step = 8'(r.step);
        num_samples = 8'(r.n);
        out_ready = 0;
        start = 1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 0;
        phase_init = 8'sd17;
        phase_step = -8'sd3;
        num_samples = 8'd99;
        hsn = 0;
        held = 0;
        got_done = 0;
        prev_s = 0;
        prev_i = 0;
        for (int c = 0; c < 4 * r.n + 10 && !got_done; c++) begin
            out_ready = r.bp ? ((c % 3) == 0) : 1'b1;
            if (done) begin
                got_done = 1;
                if (!r.bp) chk("done_cycle", edges, r.n + 1);
            end else begin
                if (out_valid && held) begin
                    chk("hold_sin", x_sin, prev_s);
                    chk("hold_idx", idx, prev_i);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("extra_sample", hsn, r.n);
                    else begin
                        e = q.pop_front();
                        chk("x_sin", x_sin, e.s);
                        chk("x_cos", x_cos, e.c);
                        chk("idx", idx, e.k);
                        obs_s[e.k] = x_sin;
                        obs_c[e.k] = x_cos;
                    end
                    hsn++;
                end
                held = out_valid && !out_ready;
                prev_s = x_sin;
                prev_i = idx;
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        chk("done_seen", got_done, 1);
        chk("handshakes", hsn, r.n);
        chk("queue_empty", q.size(), 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        runs[0] = '{0, 13, 10, 0};
        runs[1] = '{-95, -13, 3, 0};
        runs[2] = '{76, 0, 2, 0};
        runs[3] = '{30, -60, 4, 1};
        runs[4] = '{0, 0, 0, 0};
        runs[5] = '{101, 101, 6, 1};
        runs[6] = '{-101, -101, 5, 0};
        spots[0] = '{0, 8, 3, 28};
        spots[1] = '{0, 9, 16, 41};
        spots[2] = '{1, 0, -95, -70};
        spots[3] = '{1, 1, -7, 18};
        spots[4] = '{1, 2, -20, 5};
        spots[5] = '{2, 0, 76, 0};
        spots[6] = '{2, 1, 76, 0};
        spots[7] = '{5, 0, 0, 25};
        spots[8] = '{6, 1, -101, -76};

        repeat (2) @(negedge clk);
        chk("rst_x_sin", x_sin, 0);
        chk("rst_x_cos", x_cos, 0);
        chk("rst_idx", idx, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1;

        foreach (runs[i]) begin
            run(runs[i]);
            foreach (spots[j]) if (spots[j].r == i) begin
                chk("spot_sin", obs_s[spots[j].k], spots[j].s);
                chk("spot_cos", obs_c[spots[j].k], spots[j].c);
            end
        end

        // abort at idx 2: valid drops, no done, then a clean restart
        @(negedge clk);
        phase_init = 0;
        phase_step = 5;
        num_samples = 8;
        out_ready = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 20 && idx != 2; c++) @(negedge clk);
        chk("abort_reach_idx2", idx, 2);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        for (int c = 0; c < 3; c++) begin
            chk("abort_no_done", done, 0);
            @(negedge clk);
        end
        run('{10, 20, 3, 0});

        // start with abort in idle does nothing
        @(negedge clk);
        num_samples = 3;
        start = 1;
        abort = 1;
        @(negedge clk);
        start = 0;
        abort = 0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_done", done, 0);

        // asynchronous reset mid-run
        start = 1;
        num_samples = 20;
        phase_init = 40;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("pre_reset_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_x_sin", x_sin, 0);
        chk("arst_idx", idx, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_reset_done", done, 0);
        run('{-50, 33, 4, 1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
